rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rf_arb_slot.sv | 57 +++++
 rtl/rf_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
//   XLEN       : write data width
//   REG_AW     : register address width
//   NUM_REGS   : number of architectural registers (width of the pending vector)
//   wb_entry_t : one buffered writeback {rd, data}
package rf_arb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_arb_slot.sv
// One-entry holding slot for a writeback requester.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push              : load in_rd/in_data this edge (wins over pop, so a
//                       granted slot can be refilled in the same cycle)
//   in_rd, in_data    : entry being loaded
//   pop               : this slot is granted this cycle
//   other_full        : the sibling slot holds an entry
//   other_pop         : the sibling slot is granted this cycle
//   full              : slot holds an entry
//   rd, data          : held entry
//   young             : set when this entry arrived while the sibling entry
//                       was already waiting, i.e. the sibling is older
module rf_arb_slot
    import rf_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic              pop,
    input  logic              other_full,
    input  logic              other_pop,
    output logic              full,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data,
    output logic              young
);

    wb_entry_t entry_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full    <= 1'b0;
            entry_q <= '0;
            young   <= 1'b0;
        end else if (push) begin
            full    <= 1'b1;
            entry_q <= '{rd: in_rd, data: in_data};
            // Younger only if the sibling entry stays behind after this edge.
            young   <= other_full & ~other_pop;
        end else begin
            if (pop) begin
                full <= 1'b0;
            end
            // Once the sibling leaves (or this slot empties) nothing is older.
            if (pop || other_pop) begin
                young <= 1'b0;
            end
        end
    end

    assign rd   = entry_q.rd;
    assign data = entry_q.data;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback requesters (0: ALU, 1: load) onto a single
// register-file write port, each through a one-entry holding slot.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready depends only on slot state and this cycle's grant, never
// on valid. Writes to register 0 are accepted and dropped.
// Optional feature (macro RF_ARB_BYPASS_EN): two read-bypass query ports
// that hit on the write currently being issued.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   byp_rs1/2, byp_rs1/2_hit/_data : bypass queries (RF_ARB_BYPASS_EN only)
//   req0_valid/ready/rd/data       : requester 0
//   req1_valid/ready/rd/data       : requester 1
//   write_enable, rd, rd_din       : register-file write port
//   pending                        : bit k set while a slot targets register k
module rf_write_arbiter #(
    parameter int XLEN   = rf_arb_pkg::XLEN,
    parameter int REG_AW = rf_arb_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RF_ARB_BYPASS_EN
    input  logic [REG_AW-1:0] byp_rs1,
    input  logic [REG_AW-1:0] byp_rs2,
    output logic              byp_rs1_hit,
    output logic              byp_rs2_hit,
    output logic [XLEN-1:0]   byp_rs1_data,
    output logic [XLEN-1:0]   byp_rs2_data,
`endif
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              write_enable,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_din,
    output logic [31:0]       pending
);

    import rf_arb_pkg::*;

    logic              full0, full1;
    logic              young0, young1;
    logic [REG_AW-1:0] rd_q0, rd_q1;
    logic [XLEN-1:0]   data_q0, data_q1;
    logic              grant0, grant1;
    logic              toggle;
    logic              prio;
    logic              push0, push1;
    logic [NUM_REGS-1:0] pending_c;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign req0_ready = reset & (~full0 | grant0);
    assign req1_ready = reset & (~full1 | grant1);

    // Register-0 writes complete the handshake but never occupy the slot.
    assign push0 = req0_valid & req0_ready & (req0_rd != '0);
    assign push1 = req1_valid & req1_ready & (req1_rd != '0);

    rf_arb_slot u_slot0 (
        .clk        (clk),
        .reset      (reset),
        .push       (push0),
        .in_rd      (req0_rd),
        .in_data    (req0_data),
        .pop        (grant0),
        .other_full (full1),
        .other_pop  (grant1),
        .full       (full0),
        .rd         (rd_q0),
        .data       (data_q0),
        .young      (young0)
    );

    rf_arb_slot u_slot1 (
        .clk        (clk),
        .reset      (reset),
        .push       (push1),
        .in_rd      (req1_rd),
        .in_data    (req1_data),
        .pop        (grant1),
        .other_full (full0),
        .other_pop  (grant0),
        .full       (full1),
        .rd         (rd_q1),
        .data       (data_q1),
        .young      (young1)
    );

    // Same-register contention is resolved by age so the later write lands
    // last; the priority bit only rotates on genuine contention.
    // young1 is not needed: with equal arrival both flags are clear and
    // slot 0 counts as older.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        toggle = 1'b0;
        if (full0 && full1) begin
            if (rd_q0 == rd_q1) begin
                grant0 = ~young0;
                grant1 = young0;
            end else begin
                grant0 = ~prio;
                grant1 = prio;
                toggle = 1'b1;
            end
        end else if (full0) begin
            grant0 = 1'b1;
        end else if (full1) begin
            grant1 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (toggle) begin
            prio <= ~prio;
        end
    end

    always_comb begin
        write_enable = grant0 | grant1;
        rd           = '0;
        rd_din       = '0;
        if (grant0) begin
            rd     = rd_q0;
            rd_din = data_q0;
        end else if (grant1) begin
            rd     = rd_q1;
            rd_din = data_q1;
        end
    end

    always_comb begin
        pending_c = '0;
        if (full0) pending_c[rd_q0] = 1'b1;
        if (full1) pending_c[rd_q1] = 1'b1;
    end

    assign pending = pending_c;

`ifdef RF_ARB_BYPASS_EN
    assign byp_rs1_hit  = write_enable && (byp_rs1 != '0) && (byp_rs1 == rd);
    assign byp_rs2_hit  = write_enable && (byp_rs2 != '0) && (byp_rs2 == rd);
    assign byp_rs1_data = byp_rs1_hit ? rd_din : '0;
    assign byp_rs2_data = byp_rs2_hit ? rd_din : '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
// Inputs change 1ns after a rising edge; outputs are sampled 1-2ns after it.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        write_enable;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic [31:0] pending;
`ifdef RF_ARB_BYPASS_EN
    logic [4:0]  byp_rs1, byp_rs2;
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_rs1_data, byp_rs2_data;
`endif

    int checks = 0;
    int errors = 0;

    rf_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
`ifdef RF_ARB_BYPASS_EN
        .byp_rs1      (byp_rs1),
        .byp_rs2      (byp_rs2),
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_rs1_data (byp_rs1_data),
        .byp_rs2_data (byp_rs2_data),
`endif
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .write_enable (write_enable),
        .rd           (rd),
        .rd_din       (rd_din),
        .pending      (pending)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick(); tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", write_enable); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd); end
        checks++; if (rd_din !== 32'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", rd_din); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        reset = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b11) begin errors++; $display("FAIL release_ready: got %b expected 11", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single_req0();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
`ifdef RF_ARB_BYPASS_EN
        byp_rs1 = 5'd5; byp_rs2 = 5'd6;
`endif
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", write_enable); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d expected 5", rd); end
        checks++; if (rd_din !== 32'hDEADBEEF) begin errors++; $display("FAIL single_din: got %h expected deadbeef", rd_din); end
        checks++; if (pending !== 32'h0000_0020) begin errors++; $display("FAIL single_pending: got %h expected 00000020", pending); end
`ifdef RF_ARB_BYPASS_EN
        checks++; if ({byp_rs1_hit, byp_rs1_data} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL byp_rs1: got %b/%h expected 1/deadbeef", byp_rs1_hit, byp_rs1_data); end
        checks++; if ({byp_rs2_hit, byp_rs2_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL byp_rs2: got %b/%h expected 0/0", byp_rs2_hit, byp_rs2_data); end
`endif
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_idle_we: got %b expected 0", write_enable); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL single_idle_pending: got %h expected 0", pending); end
    endtask

    // Both slots loaded together with distinct rd; priority 0 -> slot 0 first.
    task automatic test_same_cycle_distinct();
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h77;
        tick();
        idle_inputs();
        #1;
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL distinct_first: got %b/%0d/%h expected 1/3/33", write_enable, rd, rd_din); end
        checks++; if (pending !== 32'h0000_0088) begin errors++; $display("FAIL distinct_pending: got %h expected 00000088", pending); end
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL distinct_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd7, 32'h77}) begin errors++; $display("FAIL distinct_second: got %b/%0d/%h expected 1/7/77", write_enable, rd, rd_din); end
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL distinct_pending2: got %h expected 00000080", pending); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL distinct_drain: got %b expected 0", write_enable); end
    endtask

    // Equal rd: older (slot 0) wins, priority bit (now 1) stays put.
    task automatic test_same_rd();
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h1;
        req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h2;
        tick();
        idle_inputs();
        #1;
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd9, 32'h1}) begin errors++; $display("FAIL samerd_first: got %b/%0d/%h expected 1/9/1", write_enable, rd, rd_din); end
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL samerd_pending: got %h expected 00000200", pending); end
        tick();
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd9, 32'h2}) begin errors++; $display("FAIL samerd_second: got %b/%0d/%h expected 1/9/2", write_enable, rd, rd_din); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL samerd_drain: got %b expected 0", write_enable); end
    endtask

    // Priority is 1 after the two tests above -> slot 1 goes first, then it flips to 0.
    task automatic test_priority_state();
        req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'hA;
        req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'hB;
        tick();
        idle_inputs();
        #1;
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd11, 32'hB}) begin errors++; $display("FAIL prio_first: got %b/%0d/%h expected 1/11/b", write_enable, rd, rd_din); end
        tick();
        checks++; if ({write_enable, rd, rd_din} !== {1'b1, 5'd10, 32'hA}) begin errors++; $display("FAIL prio_second: got %b/%0d/%h expected 1/10/a", write_enable, rd, rd_din); end
        tick();
    endtask

    task automatic test_rd_zero();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rdzero_ready: got %b expected 1", req1_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rdzero_we: got %b expected 0", write_enable); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rdzero_pending: got %h expected 0", pending); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rdzero_ready_after: got %b expected 1", req1_ready); end
    endtask

    // Priority is 0 here; sustained contention alternates 0,1,0,1 every cycle.
    task automatic test_back_to_back();
        logic [4:0]  exp_rd;
        logic [31:0] exp_din;
        logic [1:0]  exp_rdy;
        int acc0 = 0;
        int acc1 = 0;
        req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_rd = 5'd13; req1_data = 32'hB1;
        tick();
        for (int i = 0; i < 10; i++) begin
            exp_rd  = (i % 2 == 0) ? 5'd12 : 5'd13;
            exp_din = (i % 2 == 0) ? 32'hA0 : 32'hB1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if ({write_enable, rd, rd_din} !== {1'b1, exp_rd, exp_din}) begin errors++; $display("FAIL b2b_write[%0d]: got %b/%0d/%h expected 1/%0d/%h", i, write_enable, rd, rd_din, exp_rd, exp_din); end
            checks++; if ({req0_ready, req1_ready} !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, exp_rdy); end
            if (req0_ready) acc0++;
            if (req1_ready) acc1++;
            tick();
        end
        checks++; if (acc0 != 5 || acc1 != 5) begin errors++; $display("FAIL b2b_accepts: got %0d/%0d expected 5/5", acc0, acc1); end
        idle_inputs();
        #1;
        checks++; if ({write_enable, rd} !== {1'b1, 5'd12}) begin errors++; $display("FAIL b2b_drain0: got %b/%0d expected 1/12", write_enable, rd); end
        tick();
        checks++; if ({write_enable, rd} !== {1'b1, 5'd13}) begin errors++; $display("FAIL b2b_drain1: got %b/%0d expected 1/13", write_enable, rd); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", write_enable); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_rd = 5'd20; req0_data = 32'h14;
        req1_valid = 1'b1; req1_rd = 5'd21; req1_data = 32'h15;
        tick();
        idle_inputs();
        #1;
        checks++; if (pending !== 32'h0030_0000) begin errors++; $display("FAIL midrst_loaded: got %h expected 00300000", pending); end
        reset = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", write_enable); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL midrst_pending: got %h expected 0", pending); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL midrst_ready: got %b expected 00", {req0_ready, req1_ready}); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midrst_held_we: got %b expected 0", write_enable); end
        reset = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b11) begin errors++; $display("FAIL midrst_release_ready: got %b expected 11", {req0_ready, req1_ready}); end
        tick();
        checks++; if ({write_enable, pending} !== {1'b0, 32'd0}) begin errors++; $display("FAIL midrst_dropped: got %b/%h expected 0/0", write_enable, pending); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
`ifdef RF_ARB_BYPASS_EN
        byp_rs1 = '0; byp_rs2 = '0;
`endif
        test_reset();
        test_single_req0();
        test_same_cycle_distinct();
        test_same_rd();
        test_priority_state();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000ns");
        $fatal(1);
    end

endmodule
